// File: rtl/mmio_ctrl.sv
// Memory-mapped I/O decoder: RAM pass-through, output registers, synchronised inputs, edge IRQ, counter, error flag.
// Reads return two edges after the request edge with a one-cycle rd_valid; no backpressure, one access per cycle.
module mmio_ctrl #(
    parameter int                ADDR_W   = 9,
    parameter int                DATA_W   = 16,
    parameter int                NUM_OUT  = 2,
    parameter int                NUM_IN   = 2,
    parameter int                OUT_W    = 8,
    parameter int                IN_W     = 8,
    parameter logic [ADDR_W-1:0] BASE_OUT = 9'h100,
    parameter logic [ADDR_W-1:0] BASE_IN  = 9'h140
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [1:0]                mem_cmd,
    input  logic [ADDR_W-1:0]         mem_addr,
    input  logic [DATA_W-1:0]         write_data,
    output logic [DATA_W-1:0]         read_data,
    output logic                      rd_valid,
    output logic [7:0]                ram_addr,
    output logic [DATA_W-1:0]         ram_din,
    output logic                      ram_write,
    input  logic [DATA_W-1:0]         ram_dout,
    input  logic [NUM_IN*IN_W-1:0]    sw_in,
    output logic [NUM_OUT*OUT_W-1:0]  out_regs,
    output logic                      edge_irq,
    output logic                      bus_err
);

    localparam logic [ADDR_W-1:0] A_EDGE = BASE_IN + ADDR_W'(32'h20);
    localparam logic [ADDR_W-1:0] A_CNT  = BASE_IN + ADDR_W'(32'h21);
    localparam logic [ADDR_W-1:0] A_ERR  = BASE_IN + ADDR_W'(32'h22);

    logic                     w_rd;
    logic                     w_wr;
    logic                     w_hi;
    logic [ADDR_W-1:0]        w_off_out;
    logic [ADDR_W-1:0]        w_off_in;
    logic                     w_sel_ram;
    logic                     w_sel_out;
    logic                     w_sel_in;
    logic                     w_sel_edge;
    logic                     w_sel_cnt;
    logic                     w_sel_err;
    logic                     w_unmapped;
    logic [DATA_W-1:0]        w_rd_val;
    logic [NUM_IN-1:0]        w_chg;
    logic [NUM_IN-1:0]        w_edge_clr;

    logic [NUM_OUT*OUT_W-1:0] r_out;
    logic [NUM_IN*IN_W-1:0]   r_sync1;
    logic [NUM_IN*IN_W-1:0]   r_sync2;
    logic [NUM_IN*IN_W-1:0]   r_hist;
    logic [NUM_IN-1:0]        r_edge;
    logic                     r_irq;
    logic [15:0]              r_cnt;
    logic                     r_bus_err;
    logic                     r_p_vld;
    logic                     r_p_ram;
    logic [DATA_W-1:0]        r_p_dat;
    logic                     r_rd_vld;
    logic [DATA_W-1:0]        r_rd_dat;

    assign w_rd       = (mem_cmd == 2'b10);
    assign w_wr       = (mem_cmd == 2'b11);
    assign w_hi       = mem_addr[8];
    assign w_off_out  = mem_addr - BASE_OUT;
    assign w_off_in   = mem_addr - BASE_IN;
    assign w_sel_ram  = !w_hi;
    assign w_sel_out  = w_hi && (w_off_out < ADDR_W'(NUM_OUT));
    assign w_sel_in   = w_hi && (w_off_in < ADDR_W'(NUM_IN));
    assign w_sel_edge = (mem_addr == A_EDGE);
    assign w_sel_cnt  = (mem_addr == A_CNT);
    assign w_sel_err  = (mem_addr == A_ERR);
    assign w_unmapped = w_hi && !(w_sel_out || w_sel_in || w_sel_edge || w_sel_cnt || w_sel_err);

    assign ram_addr   = mem_addr[7:0];
    assign ram_din    = write_data;
    assign ram_write  = w_wr && w_sel_ram;

    assign w_edge_clr = (w_wr && w_sel_edge) ? write_data[NUM_IN-1:0] : '0;

    always_comb begin
        w_rd_val = '0;
        if (w_sel_out) begin
            for (int i = 0; i < NUM_OUT; i++) begin
                if (w_off_out == ADDR_W'(i)) begin
                    w_rd_val = DATA_W'(r_out[i*OUT_W +: OUT_W]);
                end
            end
        end else if (w_sel_in) begin
            for (int i = 0; i < NUM_IN; i++) begin
                if (w_off_in == ADDR_W'(i)) begin
                    w_rd_val = DATA_W'(r_sync2[i*IN_W +: IN_W]);
                end
            end
        end else if (w_sel_edge) begin
            w_rd_val = DATA_W'(r_edge);
        end else if (w_sel_cnt) begin
            w_rd_val = DATA_W'(r_cnt);
        end else if (w_sel_err) begin
            w_rd_val = DATA_W'(r_bus_err);
        end
    end

    // A channel has changed when the synchronised value differs from last cycle's.
    always_comb begin
        w_chg = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            w_chg[i] = (r_sync2[i*IN_W +: IN_W] != r_hist[i*IN_W +: IN_W]);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_out <= '0;
        end else if (w_wr && w_sel_out) begin
            for (int i = 0; i < NUM_OUT; i++) begin
                if (w_off_out == ADDR_W'(i)) begin
                    r_out[i*OUT_W +: OUT_W] <= write_data[OUT_W-1:0];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_hist  <= '0;
            r_edge  <= '0;
            r_irq   <= 1'b0;
        end else begin
            r_sync1 <= sw_in;
            r_sync2 <= r_sync1;
            r_hist  <= r_sync2;
            r_edge  <= (r_edge & ~w_edge_clr) | w_chg;
            r_irq   <= |r_edge;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (w_wr && w_sel_cnt) begin
            r_cnt <= 16'(write_data);
        end else begin
            r_cnt <= r_cnt + 16'd1;
        end
    end

    // A clearing write to ERR beats an error raised in the same cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_bus_err <= 1'b0;
        end else if (w_wr && w_sel_err) begin
            r_bus_err <= 1'b0;
        end else if ((w_rd || w_wr) && w_unmapped) begin
            r_bus_err <= 1'b1;
        end
    end

    // First stage captures selection and I/O value; second stage lines up with RAM read data.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_p_vld  <= 1'b0;
            r_p_ram  <= 1'b0;
            r_p_dat  <= '0;
            r_rd_vld <= 1'b0;
            r_rd_dat <= '0;
        end else begin
            r_p_vld  <= w_rd;
            r_p_ram  <= w_rd && w_sel_ram;
            r_p_dat  <= w_rd ? w_rd_val : '0;
            r_rd_vld <= r_p_vld;
            r_rd_dat <= r_p_vld ? (r_p_ram ? ram_dout : r_p_dat) : '0;
        end
    end

    assign out_regs  = r_out;
    assign edge_irq  = r_irq;
    assign bus_err   = r_bus_err;
    assign rd_valid  = r_rd_vld;
    assign read_data = r_rd_dat;

endmodule

// File: tb/tb_mmio_ctrl.sv
// Directed bench for mmio_ctrl with a behavioural synchronous RAM on the pass-through port.
module tb_mmio_ctrl;

    logic        clk;
    logic        reset_n;
    logic [1:0]  mem_cmd;
    logic [8:0]  mem_addr;
    logic [15:0] write_data;
    logic [15:0] read_data;
    logic        rd_valid;
    logic [7:0]  ram_addr;
    logic [15:0] ram_din;
    logic        ram_write;
    logic [15:0] ram_dout;
    logic [15:0] sw_in;
    logic [15:0] out_regs;
    logic        edge_irq;
    logic        bus_err;

    int checks = 0;
    int errors = 0;
    int ram_wr_cnt = 0;

    logic [15:0] ram_mem [0:255];

    mmio_ctrl dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .mem_cmd    (mem_cmd),
        .mem_addr   (mem_addr),
        .write_data (write_data),
        .read_data  (read_data),
        .rd_valid   (rd_valid),
        .ram_addr   (ram_addr),
        .ram_din    (ram_din),
        .ram_write  (ram_write),
        .ram_dout   (ram_dout),
        .sw_in      (sw_in),
        .out_regs   (out_regs),
        .edge_irq   (edge_irq),
        .bus_err    (bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_write) begin
            ram_mem[ram_addr] <= ram_din;
            ram_wr_cnt <= ram_wr_cnt + 1;
        end
        ram_dout <= ram_mem[ram_addr];
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [8:0] a, input logic [15:0] d);
        mem_cmd    = 2'b11;
        mem_addr   = a;
        write_data = d;
        step();
        mem_cmd    = 2'b00;
    endtask

    // v0: rd_valid one edge after the request edge (must be 0); v1/d: two edges after.
    task automatic do_read(input logic [8:0] a, output logic [15:0] d,
                           output logic v0, output logic v1);
        mem_cmd  = 2'b10;
        mem_addr = a;
        step();
        mem_cmd  = 2'b00;
        v0 = rd_valid;
        step();
        v1 = rd_valid;
        d  = read_data;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        step();
        step();
        checks++;
        if (out_regs !== 16'h0000 || read_data !== 16'h0000) begin
            errors++;
            $display("FAIL reset_data out_regs=%h read_data=%h expected 0000/0000", out_regs, read_data);
        end
        checks++;
        if (rd_valid !== 1'b0 || edge_irq !== 1'b0 || bus_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags rd_valid=%b edge_irq=%b bus_err=%b expected 0/0/0", rd_valid, edge_irq, bus_err);
        end
        reset_n = 1'b1;
        step();
    endtask

    task automatic test_out();
        logic [15:0] d;
        logic v0, v1;
        int wr0;
        wr0 = ram_wr_cnt;
        do_write(9'h100, 16'h00A5);
        do_write(9'h101, 16'h003C);
        checks++;
        if (out_regs !== 16'h3CA5) begin
            errors++;
            $display("FAIL out_write out_regs=%h expected 3ca5", out_regs);
        end
        checks++;
        if (ram_wr_cnt != wr0) begin
            errors++;
            $display("FAIL out_no_ram ram writes=%0d expected %0d", ram_wr_cnt, wr0);
        end
        do_read(9'h100, d, v0, v1);
        checks++;
        if (v0 !== 1'b0 || v1 !== 1'b1 || d !== 16'h00A5) begin
            errors++;
            $display("FAIL out0_read early=%b valid=%b data=%h expected 0/1/00a5", v0, v1, d);
        end
        do_read(9'h101, d, v0, v1);
        checks++;
        if (v0 !== 1'b0 || v1 !== 1'b1 || d !== 16'h003C) begin
            errors++;
            $display("FAIL out1_read early=%b valid=%b data=%h expected 0/1/003c", v0, v1, d);
        end
    endtask

    task automatic test_ram();
        logic [15:0] d;
        logic v0, v1;
        int wr0;
        wr0 = ram_wr_cnt;
        do_write(9'h012, 16'h1234);
        checks++;
        if (ram_wr_cnt != wr0 + 1) begin
            errors++;
            $display("FAIL ram_write_pulse writes=%0d expected %0d", ram_wr_cnt - wr0, 1);
        end
        do_read(9'h012, d, v0, v1);
        checks++;
        if (v0 !== 1'b0 || v1 !== 1'b1 || d !== 16'h1234) begin
            errors++;
            $display("FAIL ram_read early=%b valid=%b data=%h expected 0/1/1234", v0, v1, d);
        end
    endtask

    task automatic test_edge();
        logic [15:0] d;
        logic v0, v1;
        sw_in = 16'h8000;
        step();
        step();
        step();
        checks++;
        if (edge_irq !== 1'b0) begin
            errors++;
            $display("FAIL irq_early edge_irq=%b expected 0", edge_irq);
        end
        step();
        checks++;
        if (edge_irq !== 1'b1) begin
            errors++;
            $display("FAIL irq_cycle4 edge_irq=%b expected 1", edge_irq);
        end
        do_read(9'h160, d, v0, v1);
        checks++;
        if (v1 !== 1'b1 || d !== 16'h0002) begin
            errors++;
            $display("FAIL edge_read valid=%b data=%h expected 1/0002", v1, d);
        end
        do_read(9'h141, d, v0, v1);
        checks++;
        if (v1 !== 1'b1 || d !== 16'h0080) begin
            errors++;
            $display("FAIL in1_read valid=%b data=%h expected 1/0080", v1, d);
        end
        sw_in = 16'h8100;
        step();
        step();
        do_write(9'h160, 16'h0002);
        do_read(9'h160, d, v0, v1);
        checks++;
        if (d !== 16'h0002) begin
            errors++;
            $display("FAIL edge_set_wins data=%h expected 0002", d);
        end
        do_write(9'h160, 16'h0002);
        do_read(9'h160, d, v0, v1);
        checks++;
        if (d !== 16'h0000 || edge_irq !== 1'b0) begin
            errors++;
            $display("FAIL edge_clear data=%h edge_irq=%b expected 0000/0", d, edge_irq);
        end
    endtask

    task automatic test_cnt();
        logic [15:0] d;
        logic v0, v1;
        do_write(9'h161, 16'hFFFE);
        step();
        step();
        do_read(9'h161, d, v0, v1);
        checks++;
        if (v1 !== 1'b1 || d !== 16'h0000) begin
            errors++;
            $display("FAIL cnt_wrap valid=%b data=%h expected 1/0000", v1, d);
        end
    endtask

    task automatic test_back_to_back();
        do_write(9'h161, 16'h0010);
        mem_cmd  = 2'b10;
        mem_addr = 9'h161;
        step();
        mem_addr = 9'h100;
        step();
        checks++;
        if (rd_valid !== 1'b1 || read_data !== 16'h0010) begin
            errors++;
            $display("FAIL b2b_first valid=%b data=%h expected 1/0010", rd_valid, read_data);
        end
        mem_addr = 9'h161;
        step();
        checks++;
        if (rd_valid !== 1'b1 || read_data !== 16'h00A5) begin
            errors++;
            $display("FAIL b2b_second valid=%b data=%h expected 1/00a5", rd_valid, read_data);
        end
        mem_cmd = 2'b00;
        step();
        checks++;
        if (rd_valid !== 1'b1 || read_data !== 16'h0012) begin
            errors++;
            $display("FAIL b2b_third valid=%b data=%h expected 1/0012", rd_valid, read_data);
        end
        step();
        checks++;
        if (rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_end valid=%b expected 0", rd_valid);
        end
    endtask

    task automatic test_bus_err();
        logic [15:0] d;
        logic v0, v1;
        int wr0;
        do_read(9'h1F0, d, v0, v1);
        checks++;
        if (v1 !== 1'b1 || d !== 16'h0000 || bus_err !== 1'b1) begin
            errors++;
            $display("FAIL unmapped_read valid=%b data=%h bus_err=%b expected 1/0000/1", v1, d, bus_err);
        end
        wr0 = ram_wr_cnt;
        do_write(9'h1F0, 16'hFFFF);
        checks++;
        if (ram_wr_cnt != wr0 || out_regs !== 16'h3CA5) begin
            errors++;
            $display("FAIL unmapped_write ram writes=%0d out_regs=%h expected 0/3ca5", ram_wr_cnt - wr0, out_regs);
        end
        do_read(9'h162, d, v0, v1);
        checks++;
        if (d !== 16'h0001) begin
            errors++;
            $display("FAIL err_read data=%h expected 0001", d);
        end
        do_write(9'h162, 16'h0000);
        checks++;
        if (bus_err !== 1'b0) begin
            errors++;
            $display("FAIL err_clear bus_err=%b expected 0", bus_err);
        end
    endtask

    task automatic test_reset_pending();
        sw_in = 16'h0000;
        do_write(9'h1F1, 16'h0000);
        checks++;
        if (bus_err !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_err bus_err=%b expected 1", bus_err);
        end
        mem_cmd  = 2'b10;
        mem_addr = 9'h100;
        step();
        mem_cmd = 2'b00;
        reset_n = 1'b0;
        #1;
        checks++;
        if (rd_valid !== 1'b0 || read_data !== 16'h0000 || out_regs !== 16'h0000 ||
            edge_irq !== 1'b0 || bus_err !== 1'b0) begin
            errors++;
            $display("FAIL async_reset rd_valid=%b read_data=%h out_regs=%h edge_irq=%b bus_err=%b expected all 0",
                     rd_valid, read_data, out_regs, edge_irq, bus_err);
        end
        step();
        step();
        reset_n  = 1'b1;
        mem_cmd  = 2'b10;
        mem_addr = 9'h161;
        step();
        mem_cmd = 2'b00;
        checks++;
        if (rd_valid !== 1'b0 || read_data !== 16'h0000) begin
            errors++;
            $display("FAIL discarded_read rd_valid=%b read_data=%h expected 0/0000", rd_valid, read_data);
        end
        step();
        checks++;
        if (rd_valid !== 1'b1 || read_data !== 16'h0000) begin
            errors++;
            $display("FAIL cnt_after_reset valid=%b data=%h expected 1/0000", rd_valid, read_data);
        end
        checks++;
        if (out_regs !== 16'h0000 || edge_irq !== 1'b0 || bus_err !== 1'b0) begin
            errors++;
            $display("FAIL post_reset out_regs=%h edge_irq=%b bus_err=%b expected 0000/0/0", out_regs, edge_irq, bus_err);
        end
    endtask

    initial begin
        reset_n    = 1'b0;
        mem_cmd    = 2'b00;
        mem_addr   = 9'h000;
        write_data = 16'h0000;
        sw_in      = 16'h0000;
        test_reset();
        test_out();
        test_ram();
        test_edge();
        test_cnt();
        test_back_to_back();
        test_bus_err();
        test_reset_pending();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
